// File: rtl/trng_packer.sv
// TRNG raw-bit packer: repetition-count health test, optional von Neumann debiasing,
// MSB-first packing into Dbw-bit words with a registered one-cycle memory write strobe.
module trng_packer #(
  parameter int Dbw        = 32,
  parameter int VN_EN      = 1,
  parameter int RCT_CUTOFF = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  input  logic           raw_bit,
  input  logic           raw_valid,
  input  logic           clear_fail,
  output logic [Dbw-1:0] trng_in,
  output logic           write,
  output logic           health_fail,
  output logic [15:0]    word_cnt,
  output logic [1:0]     o_dbg_state
);

  localparam int CW = $clog2(Dbw) + 1;
  localparam int RW = $clog2(RCT_CUTOFF) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } state_t;

  state_t          r_state;
  logic [Dbw-1:0]  r_shift;
  logic [CW-1:0]   r_count;
  logic            r_pair_bit;
  logic            r_pair_full;
  logic [RW-1:0]   r_run;
  logic            r_last_bit;
  logic [Dbw-1:0]  r_trng;
  logic            r_write;
  logic            r_fail;
  logic [15:0]     r_word_cnt;

  logic [RW-1:0]   w_run_next;
  logic            w_trip;
  logic            w_accept;
  logic            w_acc_bit;
  logic            w_word_done;
  logic [Dbw-1:0]  w_shift_next;

  // A run counter of zero means no raw bit has been seen since the last clear.
  always_comb begin
    w_run_next = RW'(1);
    if (r_run != '0 && raw_bit == r_last_bit) begin
      if (r_run >= RW'(RCT_CUTOFF)) w_run_next = RW'(RCT_CUTOFF);
      else                          w_run_next = r_run + RW'(1);
    end
  end

  assign w_trip = raw_valid && (w_run_next == RW'(RCT_CUTOFF));

  always_comb begin
    w_accept  = raw_valid;
    w_acc_bit = raw_bit;
    if (VN_EN != 0) begin
      w_accept  = raw_valid && r_pair_full && (r_pair_bit != raw_bit);
      w_acc_bit = r_pair_bit;
    end
  end

  assign w_word_done  = w_accept && (r_count == CW'(Dbw - 1));
  assign w_shift_next = {r_shift[Dbw-2:0], w_acc_bit};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_count     <= '0;
      r_pair_bit  <= 1'b0;
      r_pair_full <= 1'b0;
      r_run       <= '0;
      r_last_bit  <= 1'b0;
      r_trng      <= '0;
      r_write     <= 1'b0;
      r_fail      <= 1'b0;
      r_word_cnt  <= '0;
    end else begin
      r_write <= 1'b0;
      case (r_state)
        IDLE: begin
          r_shift     <= '0;
          r_count     <= '0;
          r_pair_full <= 1'b0;
          r_pair_bit  <= 1'b0;
          r_run       <= '0;
          if (enable && !r_fail) r_state <= RUN;
        end
        RUN: begin
          if (raw_valid) begin
            r_run      <= w_run_next;
            r_last_bit <= raw_bit;
          end
          if (w_trip) begin
            r_fail      <= 1'b1;
            r_state     <= FAIL;
            r_shift     <= '0;
            r_count     <= '0;
            r_pair_full <= 1'b0;
          end else begin
            if (raw_valid && VN_EN != 0) begin
              r_pair_full <= ~r_pair_full;
              if (!r_pair_full) r_pair_bit <= raw_bit;
            end
            if (w_accept) begin
              r_shift <= w_shift_next;
              if (w_word_done) begin
                r_trng  <= w_shift_next;
                r_write <= 1'b1;
                r_count <= '0;
                if (r_word_cnt != 16'hFFFF) r_word_cnt <= r_word_cnt + 16'd1;
              end else begin
                r_count <= r_count + CW'(1);
              end
            end
            // A word completing on the same edge enable drops is still emitted above.
            if (!enable) r_state <= IDLE;
          end
        end
        FAIL: begin
          if (clear_fail) begin
            r_fail  <= 1'b0;
            r_run   <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign trng_in     = r_trng;
  assign write       = r_write;
  assign health_fail = r_fail;
  assign word_cnt    = r_word_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_trng_packer.sv
// Bench for trng_packer: one debiased and one raw instance share the bit stream,
// each with its own enable and an expected-word queue checked on every write strobe.
module tb_trng_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        raw_bit = 1'b0;
  logic        raw_valid = 1'b0;
  logic        clear_fail = 1'b0;
  logic        en_vn = 1'b0;
  logic        en_raw = 1'b0;

  logic [31:0] trng_vn, trng_raw;
  logic        write_vn, write_raw;
  logic        fail_vn, fail_raw;
  logic [15:0] wcnt_vn, wcnt_raw;
  logic [1:0]  st_vn, st_raw;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_vn = -1;
  int          last_raw = -1;
  logic [15:0] cnt_vn = 0;
  logic [15:0] cnt_raw = 0;
  logic [31:0] exp_q_vn[$];
  logic [31:0] exp_q_raw[$];
  logic [31:0] exp_w;

  typedef struct {
    bit          vn;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  trng_packer #(.Dbw(32), .VN_EN(1), .RCT_CUTOFF(32)) u_vn (
    .clk(clk), .reset_n(reset_n), .enable(en_vn), .raw_bit(raw_bit), .raw_valid(raw_valid),
    .clear_fail(clear_fail), .trng_in(trng_vn), .write(write_vn), .health_fail(fail_vn),
    .word_cnt(wcnt_vn), .o_dbg_state(st_vn)
  );

  trng_packer #(.Dbw(32), .VN_EN(0), .RCT_CUTOFF(32)) u_raw (
    .clk(clk), .reset_n(reset_n), .enable(en_raw), .raw_bit(raw_bit), .raw_valid(raw_valid),
    .clear_fail(clear_fail), .trng_in(trng_raw), .write(write_raw), .health_fail(fail_raw),
    .word_cnt(wcnt_raw), .o_dbg_state(st_raw)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe pops one expected word and checks count and spacing.
  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (write_vn) begin
        n_checks++;
        if (exp_q_vn.size() == 0) begin
          n_errors++;
          $display("FAIL vn_unexpected_write actual=%0h required=none", trng_vn);
        end else begin
          exp_w = exp_q_vn.pop_front();
          n_checks--;
          check("vn_word", trng_vn, exp_w);
        end
        cnt_vn++;
        check("vn_word_cnt", wcnt_vn, cnt_vn);
        if (last_vn >= 0) check("vn_write_gap_ge_32", (cyc - last_vn) >= 32, 1);
        last_vn = cyc;
      end
      if (write_raw) begin
        n_checks++;
        if (exp_q_raw.size() == 0) begin
          n_errors++;
          $display("FAIL raw_unexpected_write actual=%0h required=none", trng_raw);
        end else begin
          exp_w = exp_q_raw.pop_front();
          n_checks--;
          check("raw_word", trng_raw, exp_w);
        end
        cnt_raw++;
        check("raw_word_cnt", wcnt_raw, cnt_raw);
        if (last_raw >= 0) check("raw_write_gap_ge_32", (cyc - last_raw) >= 32, 1);
        last_raw = cyc;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    raw_bit   = b;
    raw_valid = 1'b1;
    tick(1);
  endtask

  task automatic send_word_raw(input logic [31:0] d);
    for (int i = 31; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic send_word_vn(input logic [31:0] d);
    for (int i = 31; i >= 0; i--) begin
      send_bit(d[i]);
      send_bit(~d[i]);
    end
  endtask

  task automatic stop_bits();
    raw_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    en_vn = 1'b0;
    en_raw = 1'b0;
    raw_valid = 1'b0;
    clear_fail = 1'b0;
    exp_q_vn.delete();
    exp_q_raw.delete();
    cnt_vn = 0;
    cnt_raw = 0;
    last_vn = -1;
    last_raw = -1;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic drained(input string name);
    stop_bits();
    tick(3);
    check({name, "_vn_queue_empty"}, exp_q_vn.size(), 0);
    check({name, "_raw_queue_empty"}, exp_q_raw.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    #1;
    // Reset values
    check("reset_write", {write_vn, write_raw}, 0);
    check("reset_trng", {trng_vn, trng_raw}, 0);
    check("reset_fail", {fail_vn, fail_raw}, 0);
    check("reset_wcnt", {wcnt_vn, wcnt_raw}, 0);
    check("reset_state", {st_vn, st_raw}, 0);
    do_reset();

    // Table-driven words; random entries keep runs short at word boundaries
    tbl[0] = '{1'b1, 32'hAAAAAAAA, 32'hAAAAAAAA};
    tbl[1] = '{1'b1, 32'h12345678, 32'h12345678};
    tbl[2] = '{1'b1, 32'hFFFF0000, 32'hFFFF0000};
    tbl[3] = '{1'b0, 32'hCCCCCCCC, 32'hCCCCCCCC};
    tbl[4] = '{1'b0, 32'h0F0F0F0F, 32'h0F0F0F0F};
    tbl[5] = '{1'b0, 32'h12345678, 32'h12345678};
    d = ($urandom & 32'h3FFFFFFC) | 32'h40000001;
    tbl[6] = '{1'b0, d, d};
    d = $urandom;
    tbl[7] = '{1'b1, d, d};
    for (int i = 0; i < 8; i++) begin
      stop_bits();
      en_vn  = tbl[i].vn;
      en_raw = ~tbl[i].vn;
      tick(2);
      if (tbl[i].vn) begin
        exp_q_vn.push_back(tbl[i].exp);
        send_word_vn(tbl[i].data);
      end else begin
        exp_q_raw.push_back(tbl[i].exp);
        send_word_raw(tbl[i].data);
      end
    end
    drained("table");

    // 1: VN pairs 10,01 repeated -> 0xAAAAAAAA words
    do_reset();
    en_vn = 1'b1;
    tick(1);
    exp_q_vn.push_back(32'hAAAAAAAA);
    exp_q_vn.push_back(32'hAAAAAAAA);
    for (int i = 0; i < 32; i++) begin
      send_bit(1); send_bit(0); send_bit(0); send_bit(1);
    end
    drained("vn_alt");
    check("vn_alt_word_cnt", wcnt_vn, 2);

    // 2: raw 1100 repeating, back-to-back words
    do_reset();
    en_raw = 1'b1;
    tick(1);
    exp_q_raw.push_back(32'hCCCCCCCC);
    exp_q_raw.push_back(32'hCCCCCCCC);
    for (int i = 0; i < 16; i++) begin
      send_bit(1); send_bit(1); send_bit(0); send_bit(0);
    end
    drained("raw_cc");
    check("raw_cc_word_cnt", wcnt_raw, 2);

    // 3: RCT boundary, trip, ignore in FAIL, clear
    do_reset();
    en_raw = 1'b1;
    tick(1);
    exp_q_raw.push_back(32'hFFFFFFFE);
    for (int i = 0; i < 31; i++) send_bit(1);
    send_bit(0);
    check("rct_31_no_fail", fail_raw, 0);
    for (int i = 0; i < 31; i++) send_bit(1);
    check("rct_31_ones_no_fail", fail_raw, 0);
    send_bit(1);
    check("rct_trip_fail", fail_raw, 1);
    check("rct_trip_state", st_raw, 2);
    check("rct_trip_no_write", write_raw, 0);
    for (int i = 0; i < 40; i++) send_bit(i[0]);
    check("fail_holds_state", st_raw, 2);
    check("fail_holds_trng", trng_raw, 32'hFFFFFFFE);
    stop_bits();
    clear_fail = 1'b1;
    tick(1);
    clear_fail = 1'b0;
    check("clear_fail_flag", fail_raw, 0);
    check("clear_fail_idle", st_raw, 0);
    tick(1);
    check("clear_fail_rerun", st_raw, 1);
    drained("rct");

    // 4: VN pairs 00,11 only -> no words, no failure
    do_reset();
    en_vn = 1'b1;
    tick(1);
    for (int i = 0; i < 250; i++) begin
      send_bit(0); send_bit(0); send_bit(1); send_bit(1);
    end
    check("vn_0011_no_fail", fail_vn, 0);
    check("vn_0011_word_cnt", wcnt_vn, 0);
    drained("vn_0011");

    // 5: async reset mid-word clears outputs at once; next word starts fresh
    do_reset();
    en_raw = 1'b1;
    tick(1);
    d = 32'h5A5A5A5A;
    exp_q_raw.push_back(d);
    send_word_raw(d);
    send_word_raw(32'h00000000 | 32'h96969696) ;
    exp_q_raw.push_back(32'h96969696);
    for (int i = 0; i < 20; i++) send_bit(i[0]);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_trng", trng_raw, 0);
    check("async_reset_write", write_raw, 0);
    check("async_reset_wcnt", wcnt_raw, 0);
    check("async_reset_state", st_raw, 0);
    do_reset();
    en_raw = 1'b1;
    tick(1);
    d = 32'h3C3C3C3C;
    exp_q_raw.push_back(d);
    send_word_raw(d);
    drained("after_reset");
    check("after_reset_wcnt", wcnt_raw, 1);

    // 6: enable drop mid-word discards the partial word
    do_reset();
    en_raw = 1'b1;
    tick(1);
    for (int i = 0; i < 16; i++) send_bit(i[1]);
    stop_bits();
    en_raw = 1'b0;
    tick(2);
    check("enable_low_idle", st_raw, 0);
    en_raw = 1'b1;
    tick(1);
    check("enable_high_run", st_raw, 1);
    d = 32'h6B6B6B6B;
    exp_q_raw.push_back(d);
    send_word_raw(d);
    drained("enable_drop");

    // 7: enable falls on the completing bit, word still emitted
    d = 32'hA5A5A5A5;
    exp_q_raw.push_back(d);
    for (int i = 31; i >= 1; i--) send_bit(d[i]);
    en_raw = 1'b0;
    send_bit(d[0]);
    check("enable_fall_done_write", write_raw, 1);
    check("enable_fall_done_trng", trng_raw, d);
    check("enable_fall_done_idle", st_raw, 0);
    drained("enable_fall");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
